bouncing_circle_engine: RTL and testbench
=========================================

# bouncing_circle_engine

Parametrised, sequential successor to the combinational circle hit-test used by the OLED drawing path. It owns a circle's position and direction registers, moves the circle once per frame tick in one of four motion modes, bounces it off the display edges, and answers pipelined per-pixel "inside circle" queries from the pixel scanner. It sits between the frame/pixel-index generator and the colour mux that drives the 96x64 OLED.

## Interface
Parameters:
- X_W, 7, pixel x coordinate width
- Y_W, 6, pixel y coordinate width
- SCREEN_W, 96, display width in pixels
- SCREEN_H, 64, display height in pixels
- RADIUS, 10, circle radius in pixels; inside test is dx²+dy² ≤ RADIUS²
- STEP, 1, pixels moved per frame tick per active axis
- X0, 48, reset centre x
- Y0, 32, reset centre y

Ports (single clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- frame_tick  in  1  one-cycle pulse, once per frame; triggers motion
- mode  in  2  00 hold, 01 horizontal, 10 vertical, 11 diagonal
- pixel_valid  in  1  query strobe for x/y this cycle
- x  in  X_W  queried pixel x
- y  in  Y_W  queried pixel y
- hit  out  1  queried pixel inside circle (valid when hit_valid)
- hit_valid  out  1  pixel_valid delayed 2 cycles
- circle_x  out  X_W  current centre x
- circle_y  out  Y_W  current centre y
- bounce_x  out  1  one-cycle pulse on x-direction reversal
- bounce_y  out  1  one-cycle pulse on y-direction reversal

## Operation
- Bounds: X_MIN=RADIUS, X_MAX=SCREEN_W-1-RADIUS, Y_MIN=RADIUS, Y_MAX=SCREEN_H-1-RADIUS (defaults 10/85, 10/53).
- Direction flags dir_x, dir_y: 0 = increasing, 1 = decreasing.
- On frame_tick, an axis moves only if enabled by mode: bit0 enables x, bit1 enables y.
  - Increasing: if pos+STEP ≥ MAX then pos←MAX, dir←1, bounce pulse; else pos←pos+STEP.
  - Decreasing: if pos ≤ MIN+STEP then pos←MIN, dir←0, bounce pulse; else pos←pos−STEP.
  - Comparisons use one extra bit of width, so there is no wrap-around.
- mode 00, or a disabled axis: position and direction are held. Direction is retained across mode changes.
- Hit pipeline:
  - Stage 1 registers |x−circle_x| and |y−circle_y| (X_W+1 / Y_W+1 bit signed difference, then absolute value) plus the valid bit.
  - Stage 2 registers hit = (dx²+dy² ≤ RADIUS²) with a sum width of 2·(X_W+1)+1 bits, plus hit_valid.
  - Queries with pixel_valid=0 propagate valid=0. hit must be 0 whenever hit_valid=0.

## Timing
- Reset values: circle_x=X0, circle_y=Y0, dir_x=dir_y=0, hit=0, hit_valid=0, bounce_x=bounce_y=0. All pipeline valids clear immediately and asynchronously.
- Position update: registered on the clock edge where frame_tick=1. New value is visible on circle_x/circle_y the next cycle.
- bounce_x/bounce_y assert for exactly the cycle following the reversing tick.
- Hit latency is 2 cycles, fully pipelined, one query per cycle.
- frame_tick and pixel_valid in the same cycle: stage 1 uses the pre-update centre.
- Queries in flight complete with the centre captured at stage 1.
- Reset asserted mid-operation: in-flight queries are discarded (hit_valid=0). Motion resumes from X0/Y0, increasing, after deassertion.
- frame_tick asserted on consecutive cycles: each cycle is a separate tick.

## Test plan
- Reset then query pixels (58,32), (59,32), (55,39), (56,40) on consecutive cycles -> hit_valid on cycles 3-6 with hit = 1, 0, 1, 0.
- mode=01, 37 ticks -> circle_x=85, bounce_x pulses once after tick 37, circle_y stays 32. Tick 38 -> circle_x=84.
- mode=11 from reset -> tick 21 gives circle_y=53 with bounce_y; tick 37 gives circle_x=85 with bounce_x. Continue until circle_x=10, at which point bounce_x pulses and dir_x returns to 0.
- mode=00 for 20 ticks after 5 ticks of mode=01 -> circle_x stays 53. Returning to mode=01 resumes increasing to 54.
- pixel_valid with x=48, y=32 in the same cycle as frame_tick (mode=01) -> hit=1 using centre 48. A query at (59,32) the next cycle uses centre 49 -> hit=1.
- Assert rst while hit_valid pipeline is full and circle_x=70 -> hit_valid=0 immediately, circle_x=48, circle_y=32, no bounce pulse. After release, the first tick gives circle_x=49.

Source files
------------

// File: rtl/bouncing_circle_engine.sv
`default_nettype none
// ============================================================================
// Module   : bouncing_circle_engine
// Brief    : Moves a circle once per frame tick in hold, horizontal, vertical
//            or diagonal mode and bounces it off the display edges. Answers
//            per-pixel "inside circle" queries through a 2-stage pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module bouncing_circle_engine #(
    parameter int X_W      = 7,
    parameter int Y_W      = 6,
    parameter int SCREEN_W = 96,
    parameter int SCREEN_H = 64,
    parameter int RADIUS   = 10,
    parameter int STEP     = 1,
    parameter int X0       = 48,
    parameter int Y0       = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_tick,
    input  logic [1:0]     mode,
    input  logic           pixel_valid,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic           hit,
    output logic           hit_valid,
    output logic [X_W-1:0] circle_x,
    output logic [Y_W-1:0] circle_y,
    output logic           bounce_x,
    output logic           bounce_y
);

    // Motion limits and step, one bit wider than the coordinate so that
    // pos+STEP and MIN+STEP never wrap.
    localparam logic [X_W:0] c_X_MIN  = (X_W+1)'(RADIUS);
    localparam logic [X_W:0] c_X_MAX  = (X_W+1)'(SCREEN_W - 1 - RADIUS);
    localparam logic [X_W:0] c_X_STEP = (X_W+1)'(STEP);
    localparam logic [X_W:0] c_X_LOW  = c_X_MIN + c_X_STEP;
    localparam logic [Y_W:0] c_Y_MIN  = (Y_W+1)'(RADIUS);
    localparam logic [Y_W:0] c_Y_MAX  = (Y_W+1)'(SCREEN_H - 1 - RADIUS);
    localparam logic [Y_W:0] c_Y_STEP = (Y_W+1)'(STEP);
    localparam logic [Y_W:0] c_Y_LOW  = c_Y_MIN + c_Y_STEP;

    // Squared-distance sum width and the squared radius threshold.
    localparam int               c_SUM_W = 2 * (X_W + 1) + 1;
    localparam logic [c_SUM_W-1:0] c_R2  = c_SUM_W'(RADIUS * RADIUS);

    // Centre position, direction (0 = increasing) and bounce pulses
    logic [X_W-1:0] r_cx;
    logic [Y_W-1:0] r_cy;
    logic           r_dir_x;
    logic           r_dir_y;
    logic           r_bx;
    logic           r_by;

    // Next-state motion values
    logic [X_W:0]   w_x_ext;
    logic [X_W:0]   w_x_inc;
    logic [Y_W:0]   w_y_ext;
    logic [Y_W:0]   w_y_inc;
    logic [X_W-1:0] w_nx;
    logic [Y_W-1:0] w_ny;
    logic           w_ndx;
    logic           w_ndy;
    logic           w_nbx;
    logic           w_nby;

    // Hit pipeline
    logic signed [X_W:0] w_dx_s;
    logic signed [Y_W:0] w_dy_s;
    logic [X_W:0]        w_dx_abs;
    logic [Y_W:0]        w_dy_abs;
    logic [X_W:0]        r_dx;
    logic [Y_W:0]        r_dy;
    logic                r_v1;
    logic [c_SUM_W-1:0]  w_dx_sq;
    logic [c_SUM_W-1:0]  w_dy_sq;
    logic [c_SUM_W-1:0]  w_sum;
    logic                r_hit;
    logic                r_hv;

    assign w_x_ext = {1'b0, r_cx};
    assign w_x_inc = w_x_ext + c_X_STEP;
    assign w_y_ext = {1'b0, r_cy};
    assign w_y_inc = w_y_ext + c_Y_STEP;

    // Next position/direction for each enabled axis on a frame tick
    always_comb begin
        w_nx  = r_cx;
        w_ny  = r_cy;
        w_ndx = r_dir_x;
        w_ndy = r_dir_y;
        w_nbx = 1'b0;
        w_nby = 1'b0;
        if (frame_tick && mode[0]) begin
            if (!r_dir_x) begin
                if (w_x_inc >= c_X_MAX) begin
                    w_nx  = c_X_MAX[X_W-1:0];
                    w_ndx = 1'b1;
                    w_nbx = 1'b1;
                end else begin
                    w_nx  = w_x_inc[X_W-1:0];
                end
            end else begin
                if (w_x_ext <= c_X_LOW) begin
                    w_nx  = c_X_MIN[X_W-1:0];
                    w_ndx = 1'b0;
                    w_nbx = 1'b1;
                end else begin
                    w_nx  = r_cx - c_X_STEP[X_W-1:0];
                end
            end
        end
        if (frame_tick && mode[1]) begin
            if (!r_dir_y) begin
                if (w_y_inc >= c_Y_MAX) begin
                    w_ny  = c_Y_MAX[Y_W-1:0];
                    w_ndy = 1'b1;
                    w_nby = 1'b1;
                end else begin
                    w_ny  = w_y_inc[Y_W-1:0];
                end
            end else begin
                if (w_y_ext <= c_Y_LOW) begin
                    w_ny  = c_Y_MIN[Y_W-1:0];
                    w_ndy = 1'b0;
                    w_nby = 1'b1;
                end else begin
                    w_ny  = r_cy - c_Y_STEP[Y_W-1:0];
                end
            end
        end
    end

    // Centre, direction and one-cycle bounce pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cx    <= X_W'(X0);
            r_cy    <= Y_W'(Y0);
            r_dir_x <= 1'b0;
            r_dir_y <= 1'b0;
            r_bx    <= 1'b0;
            r_by    <= 1'b0;
        end else begin
            r_cx    <= w_nx;
            r_cy    <= w_ny;
            r_dir_x <= w_ndx;
            r_dir_y <= w_ndy;
            r_bx    <= w_nbx;
            r_by    <= w_nby;
        end
    end

    // Stage-1 distances use the centre as it stands before any same-cycle move
    assign w_dx_s   = $signed({1'b0, x}) - $signed({1'b0, r_cx});
    assign w_dy_s   = $signed({1'b0, y}) - $signed({1'b0, r_cy});
    assign w_dx_abs = w_dx_s[X_W] ? $unsigned(-w_dx_s) : $unsigned(w_dx_s);
    assign w_dy_abs = w_dy_s[Y_W] ? $unsigned(-w_dy_s) : $unsigned(w_dy_s);

    // Stage 1: absolute axis distances plus valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_dx <= '0;
            r_dy <= '0;
        end else begin
            r_v1 <= pixel_valid;
            r_dx <= w_dx_abs;
            r_dy <= w_dy_abs;
        end
    end

    assign w_dx_sq = c_SUM_W'(r_dx) * c_SUM_W'(r_dx);
    assign w_dy_sq = c_SUM_W'(r_dy) * c_SUM_W'(r_dy);
    assign w_sum   = w_dx_sq + w_dy_sq;

    // Stage 2: radius comparison, forced low when the query is not valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit <= 1'b0;
            r_hv  <= 1'b0;
        end else begin
            r_hit <= r_v1 && (w_sum <= c_R2);
            r_hv  <= r_v1;
        end
    end

    assign hit       = r_hit;
    assign hit_valid = r_hv;
    assign circle_x  = r_cx;
    assign circle_y  = r_cy;
    assign bounce_x  = r_bx;
    assign bounce_y  = r_by;

endmodule
`default_nettype wire

// File: tb/tb_bouncing_circle_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_bouncing_circle_engine
// Brief    : Self-checking bench for bouncing_circle_engine against an
//            integer behavioural model of motion and circle hit tests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bouncing_circle_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       pixel_valid = 1'b0;
    logic [6:0] x = '0;
    logic [5:0] y = '0;
    logic       hit;
    logic       hit_valid;
    logic [6:0] circle_x;
    logic [5:0] circle_y;
    logic       bounce_x;
    logic       bounce_y;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int m_x, m_y, m_dx, m_dy;
    bit m_bx, m_by, m_p1v, m_p1h, m_hv, m_hit;

    bouncing_circle_engine dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .mode       (mode),
        .pixel_valid(pixel_valid),
        .x          (x),
        .y          (y),
        .hit        (hit),
        .hit_valid  (hit_valid),
        .circle_x   (circle_x),
        .circle_y   (circle_y),
        .bounce_x   (bounce_x),
        .bounce_y   (bounce_y)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_x = 48; m_y = 32; m_dx = 0; m_dy = 0;
        m_bx = 0; m_by = 0; m_p1v = 0; m_p1h = 0; m_hv = 0; m_hit = 0;
    endfunction

    task automatic axis_move(inout int pos, inout int dir, output bit b, input int lo, input int hi);
        b = 0;
        if (dir == 0) begin
            if (pos + 1 >= hi) begin pos = hi; dir = 1; b = 1; end
            else pos = pos + 1;
        end else begin
            if (pos <= lo + 1) begin pos = lo; dir = 0; b = 1; end
            else pos = pos - 1;
        end
    endtask

    // One clock cycle of stimulus; model advanced alongside; returns at edge+1
    task automatic cyc(input bit ft, input logic [1:0] md, input bit pv, input int px, input int py);
        frame_tick = ft; mode = md; pixel_valid = pv;
        x = px[6:0]; y = py[5:0];
        @(posedge clk);
        m_hv  = m_p1v;
        m_hit = m_p1h;
        m_p1v = pv;
        m_p1h = pv && ((px - m_x) * (px - m_x) + (py - m_y) * (py - m_y) <= 100);
        m_bx = 0; m_by = 0;
        if (ft && md[0]) axis_move(m_x, m_dx, m_bx, 10, 85);
        if (ft && md[1]) axis_move(m_y, m_dy, m_by, 10, 53);
        #1;
        frame_tick = 0; pixel_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; frame_tick = 0; pixel_valid = 0; mode = 2'b00;
        model_reset();
        #2;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; frame_tick = 0; pixel_valid = 0;
        model_reset();
        #2;
        checks++; if (circle_x !== 7'd48) begin failures++; $display("FAIL rst_cx act=%0d exp=48", circle_x); end
        checks++; if (circle_y !== 6'd32) begin failures++; $display("FAIL rst_cy act=%0d exp=32", circle_y); end
        checks++; if (hit_valid !== 1'b0) begin failures++; $display("FAIL rst_hv act=%b exp=0", hit_valid); end
        checks++; if (hit !== 1'b0) begin failures++; $display("FAIL rst_hit act=%b exp=0", hit); end
        checks++; if (bounce_x !== 1'b0 || bounce_y !== 1'b0) begin failures++; $display("FAIL rst_bounce act=%b%b exp=00", bounce_x, bounce_y); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_hit_pattern();
        int qx[4] = '{58, 59, 55, 56};
        int qy[4] = '{32, 32, 39, 40};
        bit ehv[6] = '{0, 1, 1, 1, 1, 0};
        bit eh[6]  = '{0, 1, 0, 1, 0, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) cyc(0, 2'b00, 1, qx[i], qy[i]);
            else       cyc(0, 2'b00, 0, 0, 0);
            checks++; if (hit_valid !== ehv[i] || hit !== eh[i]) begin
                failures++; $display("FAIL hitpat[%0d] act hv=%b hit=%b exp hv=%b hit=%b", i, hit_valid, hit, ehv[i], eh[i]);
            end
        end
    endtask

    task automatic test_horizontal();
        int nb = 0;
        do_reset();
        for (int t = 1; t <= 37; t++) begin
            cyc(1, 2'b01, 0, 0, 0);
            if (bounce_x) nb++;
            checks++; if (circle_x !== 7'(m_x)) begin failures++; $display("FAIL hz_x t=%0d act=%0d exp=%0d", t, circle_x, m_x); end
        end
        checks++; if (circle_x !== 7'd85 || bounce_x !== 1'b1) begin failures++; $display("FAIL hz_edge act x=%0d bx=%b exp x=85 bx=1", circle_x, bounce_x); end
        checks++; if (nb != 1) begin failures++; $display("FAIL hz_bounce_count act=%0d exp=1", nb); end
        checks++; if (circle_y !== 6'd32) begin failures++; $display("FAIL hz_y act=%0d exp=32", circle_y); end
        cyc(0, 2'b01, 0, 0, 0);
        checks++; if (bounce_x !== 1'b0) begin failures++; $display("FAIL hz_pulse_len act=%b exp=0", bounce_x); end
        cyc(1, 2'b01, 0, 0, 0);
        checks++; if (circle_x !== 7'd84) begin failures++; $display("FAIL hz_back act=%0d exp=84", circle_x); end
    endtask

    task automatic test_diagonal();
        int  t = 0;
        bit  done = 0;
        do_reset();
        while (!done && t < 200) begin
            t++;
            cyc(1, 2'b11, 0, 0, 0);
            checks++; if (circle_x !== 7'(m_x) || circle_y !== 6'(m_y) || bounce_x !== m_bx || bounce_y !== m_by) begin
                failures++; $display("FAIL diag t=%0d act x=%0d y=%0d b=%b%b exp x=%0d y=%0d b=%b%b", t, circle_x, circle_y, bounce_x, bounce_y, m_x, m_y, m_bx, m_by);
            end
            if (t == 21) begin
                checks++; if (circle_y !== 6'd53 || bounce_y !== 1'b1) begin failures++; $display("FAIL diag_t21 act y=%0d by=%b exp y=53 by=1", circle_y, bounce_y); end
            end
            if (t == 37) begin
                checks++; if (circle_x !== 7'd85 || bounce_x !== 1'b1) begin failures++; $display("FAIL diag_t37 act x=%0d bx=%b exp x=85 bx=1", circle_x, bounce_x); end
            end
            if (t > 37 && m_x == 10) done = 1;
        end
        checks++; if (!done || circle_x !== 7'd10 || bounce_x !== 1'b1) begin failures++; $display("FAIL diag_left act x=%0d bx=%b reached=%0d exp x=10 bx=1", circle_x, bounce_x, done); end
        cyc(1, 2'b11, 0, 0, 0);
        checks++; if (circle_x !== 7'd11) begin failures++; $display("FAIL diag_dir_restore act=%0d exp=11", circle_x); end
    endtask

    task automatic test_hold();
        do_reset();
        for (int t = 0; t < 5; t++) cyc(1, 2'b01, 0, 0, 0);
        checks++; if (circle_x !== 7'd53) begin failures++; $display("FAIL hold_pre act=%0d exp=53", circle_x); end
        for (int t = 0; t < 20; t++) cyc(1, 2'b00, 0, 0, 0);
        checks++; if (circle_x !== 7'd53 || circle_y !== 6'd32) begin failures++; $display("FAIL hold act x=%0d y=%0d exp 53/32", circle_x, circle_y); end
        cyc(1, 2'b01, 0, 0, 0);
        checks++; if (circle_x !== 7'd54) begin failures++; $display("FAIL hold_resume act=%0d exp=54", circle_x); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        cyc(1, 2'b01, 1, 48, 32);
        cyc(0, 2'b01, 1, 59, 32);
        checks++; if (hit_valid !== 1'b1 || hit !== 1'b1) begin failures++; $display("FAIL same_q1 act hv=%b hit=%b exp 1/1", hit_valid, hit); end
        cyc(0, 2'b01, 0, 0, 0);
        checks++; if (hit_valid !== 1'b1 || hit !== 1'b1) begin failures++; $display("FAIL same_q2 act hv=%b hit=%b exp 1/1", hit_valid, hit); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int t = 0; t < 22; t++) cyc(1, 2'b01, 0, 0, 0);
        cyc(0, 2'b01, 1, 70, 32);
        cyc(0, 2'b01, 1, 0, 0);
        checks++; if (circle_x !== 7'd70 || hit_valid !== 1'b1 || hit !== 1'b1) begin
            failures++; $display("FAIL mid_pre act x=%0d hv=%b hit=%b exp 70/1/1", circle_x, hit_valid, hit);
        end
        #1 rst = 1;
        model_reset();
        #1;
        checks++; if (hit_valid !== 1'b0 || hit !== 1'b0) begin failures++; $display("FAIL mid_hv act hv=%b hit=%b exp 0/0", hit_valid, hit); end
        checks++; if (circle_x !== 7'd48 || circle_y !== 6'd32) begin failures++; $display("FAIL mid_pos act %0d/%0d exp 48/32", circle_x, circle_y); end
        checks++; if (bounce_x !== 1'b0 || bounce_y !== 1'b0) begin failures++; $display("FAIL mid_bounce act=%b%b exp=00", bounce_x, bounce_y); end
        @(negedge clk);
        rst = 0;
        cyc(1, 2'b01, 0, 0, 0);
        checks++; if (circle_x !== 7'd49 || hit_valid !== 1'b0) begin failures++; $display("FAIL mid_resume act x=%0d hv=%b exp 49/0", circle_x, hit_valid); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int px, py;
            bit ft, pv;
            logic [1:0] md;
            md = 2'($urandom_range(0, 3));
            ft = ($urandom_range(0, 2) != 0);
            pv = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                px = m_x - 12 + int'($urandom_range(0, 24));
                py = m_y - 12 + int'($urandom_range(0, 24));
                if (px < 0) px = 0;
                if (py < 0) py = 0;
                if (py > 63) py = 63;
            end else begin
                px = int'($urandom_range(0, 127));
                py = int'($urandom_range(0, 63));
            end
            cyc(ft, md, pv, px, py);
            checks++; if (circle_x !== 7'(m_x) || circle_y !== 6'(m_y) || bounce_x !== m_bx || bounce_y !== m_by
                          || hit_valid !== m_hv || hit !== m_hit) begin
                failures++;
                $display("FAIL rand[%0d] act x=%0d y=%0d b=%b%b hv=%b hit=%b exp x=%0d y=%0d b=%b%b hv=%b hit=%b",
                         i, circle_x, circle_y, bounce_x, bounce_y, hit_valid, hit, m_x, m_y, m_bx, m_by, m_hv, m_hit);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hit_pattern();
        test_horizontal();
        test_diagonal();
        test_hold();
        test_same_cycle();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
